fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing block; the producing end of the opcode/control interface of the single-cycle MIPS core.
- Fetches words from instruction memory over a req/rvalid handshake and presents instruction, Opcode and PC to decode/execute.
- Takes Branch/Jump back from the control unit and Zero from the ALU, and computes the next PC.
- Halts on the illegal-opcode class (Opcode[4]=1).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
ADDR_W, 32, PC/address width; fixed at 32 for jump-target concatenation.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_rvalid
imem_addr  out  32  byte address of fetch (= pc)
imem_rvalid  in  1  read data valid; one outstanding request max
imem_rdata  in  32  instruction word
instr  out  32  captured instruction
opcode  out  6  instr[31:26], to control unit
instr_valid  out  1  instr/opcode/pc valid for execute
instr_ready  in  1  core retires instruction this cycle; branch/jump/zero sampled now
branch  in  1  Branch from control unit
jump  in  1  Jump from control unit
zero  in  1  ALU Zero
pc  out  32  address of current instruction
pc_plus4  out  32  pc + 4
halted  out  1  illegal opcode seen; sticky until reset

Behaviour:
- States: IDLE, FETCH, HOLD, HALT. All outputs are registered.
- Reset (async, rst_n=0):
  - state=IDLE; pc=RESET_PC.
  - imem_req=0, instr_valid=0, halted=0, instr=0.
- IDLE -> FETCH on the first clock after reset release. imem_req=1 from that edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_rvalid.
  - imem_rvalid=1 -> capture imem_rdata into instr, drop imem_req.
    - If imem_rdata[30]=1 (Opcode[4]): go to HALT, halted=1, instr_valid stays 0.
    - Otherwise go to HOLD with instr_valid=1.
  - imem_rvalid may arrive in the first request cycle (zero wait).
  - Latency: request-to-instr_valid = wait cycles + 1.
- HOLD:
  - instr_valid=1; instr, opcode and pc stable until instr_ready=1.
  - On instr_ready: instr_valid=0, pc <= next_pc, go to FETCH (imem_req=1 next cycle).
  - Minimum 2 cycles per instruction with zero-wait memory.
- next_pc, evaluated in the instr_ready cycle:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch&zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
  - All arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap the same way.
- branch/jump/zero are ignored outside the HOLD&instr_ready cycle.
- imem_rvalid outside FETCH is ignored; it must not alter instr.
- instr_ready outside HOLD is ignored.
- HALT: imem_req=0, instr_valid=0, halted=1. pc holds the offending address. Only reset exits.
- Reset mid-request (FETCH with req high): req drops asynchronously. A late imem_rvalid after restart is treated as the new request's response; the memory must not deliver stale data.
- pc_plus4 is always pc+4 (combinational from registered pc is acceptable).

Decomposition:
- Shared package:
  - State encoding (IDLE/FETCH/HOLD/HALT).
  - Opcode constants (OP_RTYPE 6'b000000, OP_J 6'b000010, OP_BEQ 6'b000100, OP_ADDIU 6'b001001, OP_ORI 6'b001101, OP_LW 6'b100011, OP_SW 6'b101011).
  - ILLEGAL_BIT=4.
- One sub-module: next_pc_calc, combinational, inputs pc_plus4/instr/branch/jump/zero, output next_pc.
- FSM and registers stay in fetch_unit.

Test Plan:
- Sequential fetch: memory at 0 returns 0x0000_0000 (R-type), zero-wait, ready every HOLD cycle -> imem_addr 0, 4, 8, …; instr_valid pulses every 2 cycles.
- Wait states: rvalid 3 cycles after req -> imem_req/imem_addr held 3 cycles; instr_valid rises the cycle after rvalid; instr stable while instr_ready=0 for 5 cycles.
- Branch taken/not-taken: pc=0x10, instr=0x1000_FFFE (beq, offset -2).
  - branch=1, zero=1 -> next pc 0x0C.
  - zero=0 -> 0x14.
- Jump and priority: pc=0x4000_0020, instr=0x0800_0040, jump=1, branch=1, zero=1 -> next pc 0x4000_0100.
- Illegal halt: rdata=0x4000_0000 (opcode 010000) -> halted=1, instr_valid never asserts, imem_req stays 0. Async rst_n pulse -> pc=RESET_PC, fetch resumes.
- Wrap and reset mid-fetch: pc=0xFFFF_FFFC, non-branch retire -> pc=0. Assert rst_n=0 while imem_req=1 -> imem_req=0 immediately, same cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and opcode constants for the fetch/decode interface
package fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam int ILLEGAL_BIT = 4;
endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc_calc: jump beats branch; branch offset is a sign-extended word offset from pc+4
module next_pc_calc (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);
  always_comb
    next_pc = jump ? {pc_plus4[31:28], instr[25:0], 2'b00}
            : (branch & zero) ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
            : pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches instructions over a req/rvalid handshake, holds them for execute, sequences the PC
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted
);
  state_t state;
  logic [31:0] next_pc;
  logic illegal;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign opcode = instr[31:26];
  assign illegal = imem_rdata[26+ILLEGAL_BIT];
  next_pc_calc u_next_pc (
    .pc_plus4(pc_plus4),
    .instr(instr),
    .branch(branch),
    .jump(jump),
    .zero(zero),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      instr_valid <= 1'b0;
      halted <= 1'b0;
      instr <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: if (imem_rvalid) begin
          instr <= imem_rdata;
          imem_req <= 1'b0;
          halted <= illegal;
          instr_valid <= !illegal;
          state <= illegal ? HALT : HOLD;
        end
        HOLD: if (instr_ready) begin
          instr_valid <= 1'b0;
          pc <= next_pc;
          imem_req <= 1'b1;
          state <= FETCH;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected fetch addresses are queued at retire and popped at each request
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_rvalid = 0, instr_valid, instr_ready = 0;
  logic branch = 0, jump = 0, zero = 0, halted;
  logic [31:0] imem_addr, imem_rdata = 0, instr, pc, pc_plus4;
  logic [5:0] opcode;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch), .jump(jump),
    .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic br, input logic jp, input logic zr);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && zr) return seq + (32'($signed(w[15:0])) << 2);
    return seq;
  endfunction
  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", imem_req, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc, RST_PC);
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    exp_q.push_back(RST_PC);
  endtask
  task automatic fetch_one(input logic [31:0] w, input int wt, input int hd,
                           input logic br, input logic jp, input logic zr);
    logic [31:0] a;
    wait_req();
    a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("imem_addr", imem_addr, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    for (int i = 0; i < wt; i++) begin
      instr_ready = 1; branch = 1; jump = 1; zero = 1;
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, a);
      check("wait_valid", instr_valid, 0);
    end
    instr_ready = 0; branch = 0; jump = 0; zero = 0;
    imem_rvalid = 1; imem_rdata = w;
    @(negedge clk);
    imem_rvalid = 0; imem_rdata = 32'hFFFF_FFFF;
    if (w[30]) begin
      check("halt_flag", halted, 1);
      check("halt_valid", instr_valid, 0);
      check("halt_req", imem_req, 0);
      check("halt_pc", pc, a);
      return;
    end
    check("cap_valid", instr_valid, 1);
    check("cap_instr", instr, w);
    check("cap_opcode", opcode, w[31:26]);
    check("cap_req", imem_req, 0);
    check("cap_pc", pc, a);
    for (int i = 0; i < hd; i++) begin
      imem_rvalid = 1; imem_rdata = ~w;
      @(negedge clk);
      imem_rvalid = 0;
      check("hold_instr", instr, w);
      check("hold_valid", instr_valid, 1);
      check("hold_req", imem_req, 0);
    end
    branch = br; jump = jp; zero = zr; instr_ready = 1;
    mpc = model_next(a, w, br, jp, zr);
    exp_q.push_back(mpc);
    @(negedge clk);
    instr_ready = 0; branch = 0; jump = 0; zero = 0;
    check("retire_valid", instr_valid, 0);
    check("retire_pc", pc, mpc);
    check("retire_req", imem_req, 1);
  endtask
  initial begin
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) fetch_one({OP_RTYPE, 26'd0}, 0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'h10);
    fetch_one(32'h1000_FFFE, 3, 5, 1, 0, 1);
    check("beq_taken", pc, 32'h0C);
    fetch_one(32'h1000_FFFE, 0, 0, 1, 0, 0);
    check("beq_not_taken", pc, 32'h10);
    for (int i = 0; i < 8192; i++) fetch_one(32'h1000_7FFF, 0, 0, 1, 0, 1);
    check("climb_pc", pc, 32'h4000_0010);
    fetch_one(32'h1000_0003, 0, 0, 1, 0, 1);
    check("beq_fwd", pc, 32'h4000_0020);
    fetch_one(32'h0800_0040, 0, 0, 1, 1, 1);
    check("jump_prio", pc, 32'h4000_0100);
    do_reset();
    fetch_one(32'h1000_FFFE, 0, 0, 1, 0, 1);
    check("neg_wrap", pc, 32'hFFFF_FFFC);
    fetch_one({OP_RTYPE, 26'd0}, 0, 0, 0, 0, 0);
    check("pc_wrap", pc, 32'h0);
    wait_req();
    a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("midfetch_addr", imem_addr, a);
    rst_n = 0;
    #1;
    check("async_req_drop", imem_req, 0);
    @(negedge clk);
    rst_n = 1;
    exp_q.push_back(RST_PC);
    fetch_one(32'h4000_0000, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1; imem_rdata = 32'h1234_5678; instr_ready = 1;
      @(negedge clk);
      imem_rvalid = 0; instr_ready = 0;
      check("halt_sticky", halted, 1);
      check("halt_no_valid", instr_valid, 0);
      check("halt_no_req", imem_req, 0);
      check("halt_pc_hold", pc, RST_PC);
      check("halt_instr", instr, 32'h4000_0000);
    end
    do_reset();
    fetch_one({OP_LW, 26'h0}, 2, 1, 0, 0, 0);
    check("resume_pc", pc, RST_PC + 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
